// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter/sequencer for one shared memory bus, with a per-transfer response watchdog.
// IDLE: arbitrate | WAIT: strobe held, await response | RESP: ack/err pulse | RELEASE: wait for response low
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  r0_req,
    input  logic                  r1_req,
    input  logic                  r0_we,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  r0_ack,
    output logic                  r1_ack,
    output logic                  r0_err,
    output logic                  r1_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic [DATA_WIDTH-1:0] mem_write_val,
    input  logic [DATA_WIDTH-1:0] mem_read_val,
    input  logic                  mem_response,
    output logic                  busy
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_RELEASE
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic                  r_last_grant;
    logic                  w_last_grant_nx;
    logic                  r_grant;
    logic                  w_grant_nx;
    logic [WDW-1:0]        r_wdog;
    logic [WDW-1:0]        w_wdog_nx;
    logic [ADDR_WIDTH-1:0] w_mem_addr_nx;
    logic                  w_mem_read_en_nx;
    logic                  w_mem_write_en_nx;
    logic [DATA_WIDTH-1:0] w_mem_write_val_nx;
    logic [DATA_WIDTH-1:0] w_r0_rdata_nx;
    logic [DATA_WIDTH-1:0] w_r1_rdata_nx;
    logic                  w_r0_ack_nx;
    logic                  w_r1_ack_nx;
    logic                  w_r0_err_nx;
    logic                  w_r1_err_nx;
    logic                  w_busy_nx;
    logic                  w_pick;
    logic                  w_pick_we;

    // A lone requester wins outright; a tie goes to the port not granted last.
    assign w_pick    = (r0_req && r1_req) ? ~r_last_grant : r1_req;
    assign w_pick_we = w_pick ? r1_we : r0_we;

    always_comb begin
        w_state_nx         = r_state;
        w_last_grant_nx    = r_last_grant;
        w_grant_nx         = r_grant;
        w_wdog_nx          = r_wdog;
        w_mem_addr_nx      = mem_addr;
        w_mem_read_en_nx   = mem_read_en;
        w_mem_write_en_nx  = mem_write_en;
        w_mem_write_val_nx = mem_write_val;
        w_r0_rdata_nx      = r0_rdata;
        w_r1_rdata_nx      = r1_rdata;
        w_r0_ack_nx        = 1'b0;
        w_r1_ack_nx        = 1'b0;
        w_r0_err_nx        = 1'b0;
        w_r1_err_nx        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!mem_response && (r0_req || r1_req)) begin
                    w_grant_nx         = w_pick;
                    w_last_grant_nx    = w_pick;
                    w_mem_addr_nx      = w_pick ? r1_addr : r0_addr;
                    w_mem_write_val_nx = w_pick ? r1_wdata : r0_wdata;
                    w_mem_read_en_nx   = ~w_pick_we;
                    w_mem_write_en_nx  = w_pick_we;
                    w_wdog_nx          = '0;
                    w_state_nx         = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response in the expiry cycle still counts as a normal completion.
                if (mem_response) begin
                    w_mem_read_en_nx  = 1'b0;
                    w_mem_write_en_nx = 1'b0;
                    if (r_grant) begin
                        w_r1_ack_nx = 1'b1;
                        if (!mem_write_en) w_r1_rdata_nx = mem_read_val;
                    end else begin
                        w_r0_ack_nx = 1'b1;
                        if (!mem_write_en) w_r0_rdata_nx = mem_read_val;
                    end
                    w_state_nx = ST_RESP;
                end else if (r_wdog == WD_LAST) begin
                    w_mem_read_en_nx  = 1'b0;
                    w_mem_write_en_nx = 1'b0;
                    if (r_grant) begin
                        w_r1_ack_nx   = 1'b1;
                        w_r1_err_nx   = 1'b1;
                        w_r1_rdata_nx = '0;
                    end else begin
                        w_r0_ack_nx   = 1'b1;
                        w_r0_err_nx   = 1'b1;
                        w_r0_rdata_nx = '0;
                    end
                    w_state_nx = ST_RESP;
                end else if (r_wdog != WD_MAX) begin
                    w_wdog_nx = r_wdog + WDW'(1);
                end
            end
            ST_RESP: begin
                w_state_nx = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!mem_response) w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        w_busy_nx = (w_state_nx != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= 1'b1;
            r_grant       <= 1'b0;
            r_wdog        <= '0;
            mem_addr      <= '0;
            mem_read_en   <= 1'b0;
            mem_write_en  <= 1'b0;
            mem_write_val <= '0;
            r0_rdata      <= '0;
            r1_rdata      <= '0;
            r0_ack        <= 1'b0;
            r1_ack        <= 1'b0;
            r0_err        <= 1'b0;
            r1_err        <= 1'b0;
            busy          <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_last_grant  <= w_last_grant_nx;
            r_grant       <= w_grant_nx;
            r_wdog        <= w_wdog_nx;
            mem_addr      <= w_mem_addr_nx;
            mem_read_en   <= w_mem_read_en_nx;
            mem_write_en  <= w_mem_write_en_nx;
            mem_write_val <= w_mem_write_val_nx;
            r0_rdata      <= w_r0_rdata_nx;
            r1_rdata      <= w_r1_rdata_nx;
            r0_ack        <= w_r0_ack_nx;
            r1_ack        <= w_r1_ack_nx;
            r0_err        <= w_r0_err_nx;
            r1_err        <= w_r1_err_nx;
            busy          <= w_busy_nx;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: the bench plays the memory, predicts each transfer from round-robin
// rules and response timing, and checks bus, ack, err and rdata cycle by cycle.
module tb_mem_bus_arbiter;

    localparam int TO = 8;

    logic        clk;
    logic        reset;
    logic        r0_req, r1_req, r0_we, r1_we;
    logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
    logic [31:0] r0_rdata, r1_rdata;
    logic        r0_ack, r1_ack, r0_err, r1_err;
    logic [31:0] mem_addr;
    logic        mem_read_en, mem_write_en;
    logic [31:0] mem_write_val;
    logic [31:0] mem_read_val;
    logic        mem_response;
    logic        busy;

    int          n_cmp;
    int          n_bad;
    logic        m_last;
    logic [31:0] exp_rd [2];
    int          lat;

    mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
        .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_rdata(r0_rdata), .r1_rdata(r1_rdata), .r0_ack(r0_ack), .r1_ack(r1_ack),
        .r0_err(r0_err), .r1_err(r1_err), .mem_addr(mem_addr), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .mem_write_val(mem_write_val), .mem_read_val(mem_read_val),
        .mem_response(mem_response), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        n_cmp++;
        if ((mem_read_en && mem_write_en) || (r0_ack && r1_ack)) begin
            n_bad++;
            $display("FAIL exclusive: rd_en=%0b wr_en=%0b ack0=%0b ack1=%0b, want at most one of each",
                     mem_read_en, mem_write_en, r0_ack, r1_ack);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        r0_req = 1'b0; r1_req = 1'b0; r0_we = 1'b0; r1_we = 1'b0;
        mem_response = 1'b0; mem_read_val = '0;
        tick();
        tick();
        reset = 1'b0;
        m_last = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    // One transfer: response at WAIT cycle d+1 (timeout if beyond TO), then gap cycles with the
    // response low and hold cycles with a stray response high, during which nothing may be granted.
    task automatic run_xfer(input int d, input int gap, input int hold, input bit scramble,
                            input logic [31:0] rval, output int lat_o);
        logic        ep, ewe, got_resp, experr;
        logic [31:0] ea, ewd;
        logic [1:0]  ack_exp, err_exp;
        bit          seen;
        int          k;
        ep  = (r0_req && r1_req) ? ~m_last : r1_req;
        ewe = ep ? r1_we : r0_we;
        ea  = ep ? r1_addr : r0_addr;
        ewd = ep ? r1_wdata : r0_wdata;
        seen = 1'b0;
        lat_o = 0;
        for (int i = 1; i <= 8 && !seen; i++) begin
            tick();
            lat_o = i;
            n_cmp++;
            if (r0_ack || r1_ack) begin
                n_bad++;
                $display("FAIL ack_pulse: ack0=%0b ack1=%0b before grant, want 0", r0_ack, r1_ack);
            end
            if (mem_read_en || mem_write_en) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL grant_wait: no strobe within 8 cycles, want a grant");
            return;
        end
        m_last = ep;
        n_cmp++;
        if (mem_addr !== ea) begin
            n_bad++;
            $display("FAIL grant_addr: got %h want %h (port %0d)", mem_addr, ea, ep);
        end
        n_cmp++;
        if ({mem_write_en, mem_read_en, busy} !== {ewe, ~ewe, 1'b1}) begin
            n_bad++;
            $display("FAIL grant_strobe: wr/rd/busy=%b want %b", {mem_write_en, mem_read_en, busy},
                     {ewe, ~ewe, 1'b1});
        end
        if (scramble) begin
            r0_req = 1'b0; r1_req = 1'b0;
            r0_addr = $urandom; r1_addr = $urandom; r0_wdata = $urandom; r1_wdata = $urandom;
        end
        got_resp = 1'b0;
        for (k = 1; k <= TO; k++) begin
            n_cmp++;
            if ({mem_write_en, mem_read_en, mem_addr, (ewe ? mem_write_val : ewd)} !==
                {ewe, ~ewe, ea, ewd}) begin
                n_bad++;
                $display("FAIL wait_hold: cycle %0d wr=%0b rd=%0b addr=%h wval=%h want wr=%0b addr=%h wval=%h",
                         k, mem_write_en, mem_read_en, mem_addr, mem_write_val, ewe, ea, ewd);
            end
            if (k == d + 1) begin
                mem_response = 1'b1;
                mem_read_val = rval;
                got_resp = 1'b1;
            end
            tick();
            if (got_resp || k == TO) break;
            n_cmp++;
            if (r0_ack || r1_ack) begin
                n_bad++;
                $display("FAIL early_ack: cycle %0d ack0=%0b ack1=%0b want 0", k, r0_ack, r1_ack);
            end
        end
        experr = ~got_resp;
        if (experr)    exp_rd[ep] = '0;
        else if (!ewe) exp_rd[ep] = rval;
        ack_exp = ep ? 2'b10 : 2'b01;
        err_exp = experr ? ack_exp : 2'b00;
        n_cmp++;
        if ({r1_ack, r0_ack} !== ack_exp) begin
            n_bad++;
            $display("FAIL ack: got %b want %b", {r1_ack, r0_ack}, ack_exp);
        end
        n_cmp++;
        if ({r1_err, r0_err} !== err_exp) begin
            n_bad++;
            $display("FAIL err: got %b want %b", {r1_err, r0_err}, err_exp);
        end
        n_cmp++;
        if ((ep ? r1_rdata : r0_rdata) !== exp_rd[ep]) begin
            n_bad++;
            $display("FAIL rdata: port %0d got %h want %h", ep, ep ? r1_rdata : r0_rdata, exp_rd[ep]);
        end
        n_cmp++;
        if (mem_read_en || mem_write_en) begin
            n_bad++;
            $display("FAIL strobe_drop: rd=%0b wr=%0b at ack, want 0", mem_read_en, mem_write_en);
        end
        for (int i = 0; i < gap + hold; i++) begin
            mem_response = (i >= gap);
            tick();
            n_cmp++;
            if (mem_read_en || mem_write_en || r0_ack || r1_ack) begin
                n_bad++;
                $display("FAIL after_ack: step %0d rd=%0b wr=%0b ack0=%0b ack1=%0b want all 0",
                         i, mem_read_en, mem_write_en, r0_ack, r1_ack);
            end
        end
        mem_response = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({mem_read_en, mem_write_en, r0_ack, r1_ack, r0_err, r1_err, busy} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {mem_read_en, mem_write_en, r0_ack, r1_ack, r0_err, r1_err, busy});
        end
        n_cmp++;
        if ({mem_addr, mem_write_val, r0_rdata, r1_rdata} !== 128'b0) begin
            n_bad++;
            $display("FAIL reset_data: addr=%h wval=%h rd0=%h rd1=%h want 0",
                     mem_addr, mem_write_val, r0_rdata, r1_rdata);
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h10;
        run_xfer(0, 0, 0, 1'b1, 32'hDEADBEEF, lat);
        n_cmp++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL read_latency: strobe after %0d cycles want 1", lat);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h100;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            run_xfer(0, 0, 0, 1'b0, $urandom, lat);
            n_cmp++;
            if (mem_addr !== ((i % 2 == 1) ? 32'h200 : 32'h100)) begin
                n_bad++;
                $display("FAIL rr_order: transfer %0d addr %h want port %0d", i, mem_addr, i % 2);
            end
            if (i > 0) begin
                n_cmp++;
                if (lat !== 3) begin
                    n_bad++;
                    $display("FAIL back_to_back: grant gap %0d want 4", lat + 1);
                end
            end
        end
        r0_req = 1'b0; r1_req = 1'b0;
    endtask

    task automatic test_write_delay();
        apply_reset();
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'h04; r0_wdata = 32'h55AA;
        run_xfer(3, 1, 0, 1'b1, 32'h12345678, lat);
    endtask

    task automatic test_timeout();
        apply_reset();
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h80;
        run_xfer(0, 0, 0, 1'b0, 32'hA5A5A5A5, lat);
        run_xfer(100, 2, 2, 1'b0, 32'h0, lat);
        r1_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h300; r1_req = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (mem_read_en !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_setup: rd_en=%0b in second WAIT cycle want 1", mem_read_en);
        end
        reset = 1'b1;
        r0_req = 1'b0;
        tick();
        reset = 1'b0;
        m_last = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        n_cmp++;
        if ({mem_read_en, mem_write_en, r0_ack, r1_ack, r0_err, r1_err, busy, mem_addr} !== 39'b0) begin
            n_bad++;
            $display("FAIL mid_reset: ctrl=%b addr=%h want 0",
                     {mem_read_en, mem_write_en, r0_ack, r1_ack, r0_err, r1_err, busy}, mem_addr);
        end
        tick();
        n_cmp++;
        if (r0_ack || r1_ack || busy) begin
            n_bad++;
            $display("FAIL mid_noack: ack0=%0b ack1=%0b busy=%0b want 0", r0_ack, r1_ack, busy);
        end
        r0_req = 1'b1; r0_addr = 32'h400; r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h500;
        run_xfer(1, 0, 0, 1'b1, $urandom, lat);
        n_cmp++;
        if (mem_addr !== 32'h400) begin
            n_bad++;
            $display("FAIL mid_tie: addr %h want %h (port 0)", mem_addr, 32'h400);
        end
    endtask

    task automatic test_coincide();
        apply_reset();
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h600;
        run_xfer(TO - 1, 0, 1, 1'b1, 32'hCAFEF00D, lat);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            r0_req = 1'($urandom); r1_req = 1'($urandom);
            if (!r0_req && !r1_req) r0_req = 1'b1;
            r0_we = 1'($urandom); r1_we = 1'($urandom);
            r0_addr = $urandom; r1_addr = $urandom; r0_wdata = $urandom; r1_wdata = $urandom;
            run_xfer(int'($urandom_range(0, TO + 1)), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 3)), 1'($urandom), $urandom, lat);
        end
        r0_req = 1'b0; r1_req = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        r0_req = 1'b0; r1_req = 1'b0; r0_we = 1'b0; r1_we = 1'b0;
        r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
        mem_read_val = '0; mem_response = 1'b0;
        m_last = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_delay();
        test_timeout();
        test_reset_mid();
        test_coincide();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and sequencer for the single shared memory bus (`mem_addr`, `mem_read_en`, `mem_write_en`, `mem_write_val`, `mem_read_val`, `mem_response`). Port 0 is the instruction-fetch requester and port 1 is the data-memory requester. Grants alternate round-robin, and each transfer is held on the bus until `mem_response` is sampled. A watchdog terminates any transfer whose response never arrives.

## Interface
- `ADDR_WIDTH`, 32, width of requester and memory addresses
- `DATA_WIDTH`, 32, width of read and write data
- `TIMEOUT`, 255, maximum cycles spent in WAIT per transfer (≥1)

- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `r0_req`, `r1_req`  in  1  transfer request, level
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read
- `r0_addr`, `r1_addr`  in  ADDR_WIDTH  transfer address
- `r0_wdata`, `r1_wdata`  in  DATA_WIDTH  write data
- `r0_rdata`, `r1_rdata`  out  DATA_WIDTH  read data, valid while `rN_ack`=1
- `r0_ack`, `r1_ack`  out  1  one-cycle completion pulse
- `r0_err`, `r1_err`  out  1  one-cycle timeout flag, coincident with `rN_ack`
- `mem_addr`  out  ADDR_WIDTH  latched transfer address
- `mem_read_en`  out  1  read strobe, held through WAIT
- `mem_write_en`  out  1  write strobe, held through WAIT
- `mem_write_val`  out  DATA_WIDTH  latched write data
- `mem_read_val`  in  DATA_WIDTH  read data, valid when `mem_response`=1
- `mem_response`  in  1  memory completion, level-sampled
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, WAIT, RESP, RELEASE. All outputs are registered.
- **IDLE**
  - Arbitration only when `mem_response`=0.
  - One requester high: grant it.
  - Both high: grant the port not granted last (`last_grant`).
  - On grant: latch addr, we and wdata into the bus registers; set `mem_read_en`=~we and `mem_write_en`=we; clear the watchdog; update `last_grant`; go to WAIT.
- **WAIT**
  - Strobes and bus registers are held constant.
  - `mem_response`=1 sampled: drop both strobes; capture `mem_read_val` into the granted port's rdata (reads only; writes leave rdata unchanged); assert the granted `rN_ack`; go to RESP.
  - Watchdog at TIMEOUT-1 with `mem_response`=0: drop the strobes; assert `rN_ack` and `rN_err`; set rdata to 0; go to RESP.
  - Response and expiry in the same cycle: the response wins, with no error.
- **RESP** (one cycle; ack/err visible)
  - Clears ack and err.
  - Goes to RELEASE.
- **RELEASE**
  - Waits until `mem_response`=0, then goes to IDLE.
  - A late response after a timeout is absorbed here or blocked in IDLE. It is never delivered to a requester.
- **Requester rule**
  - The transfer is captured at grant, so dropping `rN_req` or changing its addr/wdata mid-transfer has no effect. The ack is still issued.
  - `rN_req` still high in IDLE after its ack counts as a new request.
- **Watchdog:** width $clog2(TIMEOUT+1). It increments once per WAIT cycle and saturates.
- **Exclusivity:** at most one of `mem_read_en` / `mem_write_en` is high. At most one `rN_ack` is high.

## Timing
- **Reset:**
  - All outputs are 0: strobes, `mem_addr`, `mem_write_val`, both rdata, acks, errs, `busy`.
  - State is IDLE.
  - `last_grant`=1, so port 0 wins the first tie.
- **Reset mid-transfer:** strobes are 0 in the next cycle and no ack is issued.
- **Minimum latency:**
  - Request sampled at edge E0.
  - Strobe high in cycle E0+1.
  - `mem_response` high in that same cycle is sampled at E0+2.
  - `rN_ack` is high during cycle E0+2.
  - Request to ack is therefore 2 cycles.
- **General latency:** a response first sampled at WAIT cycle k gives an ack at cycle k+1 after the grant. A timeout gives an ack at cycle TIMEOUT+1.
- **Back-to-back minimum:** IDLE→WAIT→RESP→RELEASE→IDLE gives one grant every 4 cycles when the response drops promptly.
- **Strobe duration:** strobes are high for exactly the WAIT cycles and never high in RESP or RELEASE.

## Test plan
- Port 1 read of addr 0x10; memory returns 0xDEADBEEF with `mem_response` in the first WAIT cycle. Expect `mem_read_en`=1 for 1 cycle, `mem_addr`=0x10, `r1_ack`=1 two cycles after the request with `r1_rdata`=0xDEADBEEF, and `r1_err`=0.
- Port 0 and port 1 request simultaneously right after reset, both held for 4 transfers. Expect grants in the order 0,1,0,1 and never two strobes at once.
- Port 0 write of 0x55AA to addr 0x04; response delayed 3 cycles. Expect `mem_write_en` held 4 cycles, `mem_write_val`=0x55AA throughout, and a single `r0_ack`.
- `TIMEOUT`=8 with no response. Expect the strobe high 8 cycles, `r1_ack`=`r1_err`=1 and `r1_rdata`=0. A response arriving 2 cycles later is ignored, and the next grant waits until it drops.
- `reset` asserted in the 2nd WAIT cycle. Expect all outputs 0 in the next cycle, no ack, and port 0 granted first on the following tie.
- Response and watchdog expiry coincide. Expect ack with `err`=0 and the captured data delivered.
